pipe_stage_buf: RTL

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf_if.sv | 34 +++
 rtl/pipe_stage_buf.sv | 108 ++++++++++
 2 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for pipe_stage_buf: upstream push side and
// downstream pop side grouped together.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Producer/consumer side that surrounds the buffer
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // The buffer itself
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_stage_buf.sv
// Registered FIFO pipeline stage: DEPTH entries, one cycle latency, no
// fall-through, enable freeze, flush, and a saturating stall counter.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         enable,
  input  logic                         flush,
  pipe_stage_buf_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  stall_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Saturating increment: the stall counter sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pointer advance that wraps at DEPTH-1, so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [15:0]      stall_q,  stall_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Handshake qualifiers depend only on local state and enable/flush, never
  // on out_ready, so there is no combinational path through the stage.
  assign in_ready  = enable & ~flush & (count_q < DEPTH_C);
  assign out_valid = enable & ~flush & (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count         = count_q;
  assign stall_cnt     = stall_q;

  // Next-state for pointers, occupancy and stall counter; flush clears
  // occupancy but leaves the stall statistic alone.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (out_valid && !bus.out_ready) begin
        stall_d = sat_inc16(stall_q);
      end
    end
  end

  // Control state register with synchronous reset taking priority over all.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule
